// File: rtl/eq_queue_pkg.sv
// Shared types and constants for the equalizer sample-queue controllers.
package eq_queue_pkg;

    // Width of one audio sample as stored in the sample RAM.
    localparam int SMPL_W = 16;

    // Readout sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } seq_state_e;

endpackage : eq_queue_pkg

// File: rtl/queue_seq_ctrl_if.sv
// Dual-port sample RAM bus: write port, read port and read data return.
interface queue_seq_ctrl_if
    import eq_queue_pkg::*;
#(
    parameter int AW = 10
);

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [SMPL_W-1:0] ram_wdata;
    logic              ram_re;
    logic [AW-1:0]     ram_raddr;
    logic [SMPL_W-1:0] ram_rdata;

    // Controller side: drives both RAM ports, receives read data.
    modport master (
        output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
        input  ram_rdata
    );

    // RAM side.
    modport slave (
        input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
        output ram_rdata
    );

endinterface : queue_seq_ctrl_if

// File: rtl/smpl_strobe_decim.sv
// Sample strobe front end: rising-edge detect on the level strobe, keep one
// edge in DECIM, and present a one-cycle accept pulse with the captured sample
// in the cycle after the edge was seen.
module smpl_strobe_decim
    import eq_queue_pkg::*;
#(
    parameter int DECIM = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wrt_smpl,
    input  logic [SMPL_W-1:0] i_new_smpl,
    output logic              o_accept,
    output logic [SMPL_W-1:0] o_smpl
);

    // A 1-bit counter is kept even for DECIM=1; it simply never leaves 0.
    localparam int            CW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

    logic              r_wrt_q;
    logic [CW-1:0]     r_cnt;
    logic              r_accept;
    logic [SMPL_W-1:0] r_smpl;
    logic              w_edge;
    logic              w_keep;

    assign w_edge = i_wrt_smpl & ~r_wrt_q;
    // Counter at 0 keeps the edge, so the first edge after reset is always kept.
    assign w_keep = w_edge & (r_cnt == '0);

    // Edge history, decimation phase, accept pulse and sample capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrt_q  <= 1'b0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
            r_smpl   <= '0;
        end else begin
            r_wrt_q  <= i_wrt_smpl;
            r_accept <= w_keep;
            if (w_keep) begin
                r_smpl <= i_new_smpl;
            end
            if (w_edge) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign o_accept = r_accept;
    assign o_smpl   = r_smpl;

endmodule : smpl_strobe_decim

// File: rtl/queue_seq_ctrl.sv
// Circular sample-queue controller: writes each kept sample into the sample
// RAM and, once READ_LEN samples are held, reads the whole window oldest-first
// after every new sample. A request arriving mid-burst is remembered once
// (pending) and restarts the burst back-to-back; a further one is flagged as
// overrun.
module queue_seq_ctrl
    import eq_queue_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int READ_LEN = 1021,
    parameter int DECIM    = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic [SMPL_W-1:0] new_smpl,
    queue_seq_ctrl_if.master  ram,
    output logic [SMPL_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic              sequencing,
    output logic              full,
    output logic              overrun
);

    localparam int            FW        = $clog2(READ_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(READ_LEN);
    localparam logic [FW-1:0] FILL_LAST = FW'(READ_LEN - 1);
    localparam logic [FW-1:0] RD_LAST   = FW'(READ_LEN - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [AW-1:0]     r_new_ptr;
    logic [AW-1:0]     r_old_ptr;
    logic [AW-1:0]     w_old_nxt;
    logic [FW-1:0]     r_fill;
    logic [AW-1:0]     r_rd_ptr;
    logic [FW-1:0]     r_rd_cnt;
    logic              r_pending;
    logic              r_overrun;
    logic              r_smpl_vld;
    logic              w_we;
    logic [SMPL_W-1:0] w_wdata;
    logic              w_full;
    logic              w_req;
    logic              w_load;
    logic              w_rd_last;
    logic              w_ram_re;

    smpl_strobe_decim #(
        .DECIM (DECIM)
    ) u_strobe (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wrt_smpl (wrt_smpl),
        .i_new_smpl (new_smpl),
        .o_accept   (w_we),
        .o_smpl     (w_wdata)
    );

    assign w_full = (r_fill == FILL_MAX);
    // Readout is requested by the write that completes the window and by every
    // write after that.
    assign w_req  = w_we & (w_full | (r_fill == FILL_LAST));
    // A burst started in a write cycle must begin at the post-write oldest
    // sample, so the reload uses the old pointer's next value.
    assign w_old_nxt = (w_we & w_full) ? ptr_inc(r_old_ptr) : r_old_ptr;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state, burst (re)load and read strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rd_last   = 1'b0;
        w_ram_re    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req | r_pending) begin
                    w_state_nxt = READ;
                    w_load      = 1'b1;
                end
            end
            READ: begin
                w_ram_re = 1'b1;
                if (r_rd_cnt == RD_LAST) begin
                    w_rd_last = 1'b1;
                    if (w_req | r_pending) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write pointer, oldest-sample pointer and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_ptr <= '0;
            r_old_ptr <= '0;
            r_fill    <= '0;
        end else if (w_we) begin
            r_new_ptr <= ptr_inc(r_new_ptr);
            if (w_full) begin
                r_old_ptr <= ptr_inc(r_old_ptr);
            end else begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Burst read pointer and read counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_rd_cnt <= '0;
        end else if (w_load) begin
            r_rd_ptr <= w_old_nxt;
            r_rd_cnt <= '0;
        end else if (r_state == READ) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    // Pending restart and sticky overrun for requests arriving during a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == READ) begin
            if (w_rd_last) begin
                // The restart taken here consumes one request; two in hand
                // means one was lost.
                r_pending <= 1'b0;
                if (w_req & r_pending) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_req) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    // Read data returns one cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smpl_vld <= 1'b0;
        end else begin
            r_smpl_vld <= w_ram_re;
        end
    end

    assign ram.ram_we    = w_we;
    assign ram.ram_waddr = r_new_ptr;
    assign ram.ram_wdata = w_wdata;
    assign ram.ram_re    = w_ram_re;
    assign ram.ram_raddr = r_rd_ptr;

    assign smpl_out   = ram.ram_rdata;
    assign smpl_vld   = r_smpl_vld;
    assign sequencing = (r_state == READ);
    assign full       = w_full;
    assign overrun    = r_overrun;

endmodule : queue_seq_ctrl

// File: tb/tb_queue_seq_ctrl.sv
// Bench for queue_seq_ctrl: one instance without and one with 2:1 decimation,
// both fed the same strobe stream, each against a synchronous RAM and a
// window-level reference model with a decoupled scoreboard monitor.
module tb_queue_seq_ctrl;

    localparam int DEPTH    = 8;
    localparam int READ_LEN = 5;
    localparam int AW       = $clog2(DEPTH);

    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wrt_smpl;
    logic [15:0] new_smpl;

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input int inst, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (decim %0d) at %0t: actual 0x%0h required 0x%0h",
                     name, inst + 1, $time, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int DEC = g + 1;

        queue_seq_ctrl_if #(.AW(AW)) bus ();
        logic [15:0] smpl_out;
        logic        smpl_vld;
        logic        sequencing;
        logic        full;
        logic        overrun;

        queue_seq_ctrl #(
            .DEPTH    (DEPTH),
            .READ_LEN (READ_LEN),
            .DECIM    (DEC),
            .AW       (AW)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .wrt_smpl   (wrt_smpl),
            .new_smpl   (new_smpl),
            .ram        (bus),
            .smpl_out   (smpl_out),
            .smpl_vld   (smpl_vld),
            .sequencing (sequencing),
            .full       (full),
            .overrun    (overrun)
        );

        // Synchronous sample RAM.
        logic [15:0] mem [DEPTH];
        always @(posedge clk) begin
            if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
            if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
        end

        // Reference model state: every kept sample since reset, in order.
        int          cyc = 0;
        int          m_count;
        int          edge_n;
        int          burst_start;
        int          burst_last;
        bit          wr_sched;
        bit          prev_wrt;
        bit          burst_act;
        bit          pending;
        bit          exp_ovr;
        logic [15:0] wr_val;
        logic [15:0] hist [$];
        exp_t        exp_rd [$];
        exp_t        exp_vd [$];

        // A burst starting in cycle s reads the newest READ_LEN kept samples,
        // oldest first; sample number k lives at address k mod DEPTH.
        task automatic start_burst(input int s);
            burst_act   = 1'b1;
            burst_start = s;
            burst_last  = s + READ_LEN - 1;
            for (int i = 0; i < READ_LEN; i++) begin
                int idx;
                idx = m_count - READ_LEN + i;
                exp_rd.push_back('{cyc: s + i,     addr: idx % DEPTH, data: int'(hist[idx])});
                exp_vd.push_back('{cyc: s + i + 1, addr: idx % DEPTH, data: int'(hist[idx])});
            end
        endtask

        // Model step for the cycle ending at this edge.
        always @(posedge clk) begin
            bit req;
            req = 1'b0;
            if (!rst_n) begin
                m_count   = 0;
                edge_n    = 0;
                wr_sched  = 1'b0;
                prev_wrt  = 1'b0;
                burst_act = 1'b0;
                pending   = 1'b0;
                exp_ovr   = 1'b0;
                hist.delete();
                exp_rd.delete();
                exp_vd.delete();
            end else begin
                if (wr_sched) begin
                    hist.push_back(wr_val);
                    m_count++;
                    req      = (m_count >= READ_LEN);
                    wr_sched = 1'b0;
                end
                if (wrt_smpl && !prev_wrt) begin
                    if (edge_n % DEC == 0) begin
                        wr_sched = 1'b1;
                        wr_val   = new_smpl;
                    end
                    edge_n++;
                end
                prev_wrt = wrt_smpl;
                if (burst_act && cyc == burst_last) begin
                    if (pending || req) begin
                        if (pending && req) exp_ovr = 1'b1;
                        pending = 1'b0;
                        start_burst(cyc + 1);
                    end else begin
                        burst_act = 1'b0;
                    end
                end else if (burst_act) begin
                    if (req) begin
                        if (pending) exp_ovr = 1'b1;
                        pending = 1'b1;
                    end
                end else if (req) begin
                    start_burst(cyc + 1);
                end
            end
            cyc++;
        end

        // Monitor: compare DUT outputs mid-cycle against the model.
        always @(negedge clk) begin
            if (!rst_n) begin
                chk(g, "rst_ram_we",     32'(bus.ram_we),    0);
                chk(g, "rst_ram_waddr",  32'(bus.ram_waddr), 0);
                chk(g, "rst_ram_wdata",  32'(bus.ram_wdata), 0);
                chk(g, "rst_ram_re",     32'(bus.ram_re),    0);
                chk(g, "rst_ram_raddr",  32'(bus.ram_raddr), 0);
                chk(g, "rst_smpl_vld",   32'(smpl_vld),      0);
                chk(g, "rst_sequencing", 32'(sequencing),    0);
                chk(g, "rst_full",       32'(full),          0);
                chk(g, "rst_overrun",    32'(overrun),       0);
            end else begin
                chk(g, "ram_we", 32'(bus.ram_we), 32'(wr_sched));
                if (wr_sched) begin
                    chk(g, "ram_waddr", 32'(bus.ram_waddr), m_count % DEPTH);
                    chk(g, "ram_wdata", 32'(bus.ram_wdata), 32'(wr_val));
                end
                chk(g, "sequencing", 32'(sequencing),
                    32'(burst_act && cyc >= burst_start && cyc <= burst_last));
                chk(g, "full",    32'(full),    32'(m_count >= READ_LEN));
                chk(g, "overrun", 32'(overrun), 32'(exp_ovr));
                if (exp_rd.size() != 0 && exp_rd[0].cyc == cyc) begin
                    chk(g, "ram_re",    32'(bus.ram_re),    1);
                    chk(g, "ram_raddr", 32'(bus.ram_raddr), exp_rd[0].addr);
                    void'(exp_rd.pop_front());
                end else begin
                    chk(g, "ram_re", 32'(bus.ram_re), 0);
                end
                if (exp_vd.size() != 0 && exp_vd[0].cyc == cyc) begin
                    chk(g, "smpl_vld", 32'(smpl_vld), 1);
                    chk(g, "smpl_out", 32'(smpl_out), exp_vd[0].data);
                    void'(exp_vd.pop_front());
                end else begin
                    chk(g, "smpl_vld", 32'(smpl_vld), 0);
                end
            end
        end

        // Asynchronous reset must clear the burst outputs without a clock.
        always @(negedge rst_n) begin
            #1;
            chk(g, "async_rst_sequencing", 32'(sequencing), 0);
            chk(g, "async_rst_ram_re",     32'(bus.ram_re), 0);
            chk(g, "async_rst_full",       32'(full),       0);
            chk(g, "async_rst_overrun",    32'(overrun),    0);
        end
    end

    // One strobe: high for hi cycles (data valid only in the edge cycle), then
    // low for lo cycles.
    task automatic strobe(input logic [15:0] v, input int hi, input int lo);
        @(negedge clk);
        wrt_smpl = 1'b1;
        new_smpl = v;
        for (int i = 1; i < hi; i++) begin
            @(negedge clk);
            new_smpl = 16'($urandom);
        end
        @(negedge clk);
        wrt_smpl = 1'b0;
        new_smpl = 16'($urandom);
        for (int i = 1; i < lo; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        wrt_smpl = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        wrt_smpl = 1'b0;
        new_smpl = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fill then wrap: samples 1..10, spaced so each burst completes.
        for (int v = 1; v <= 10; v++) strobe(16'(v), 1, 7);

        // Strobe held high for 20 cycles.
        strobe(16'h0100, 20, 8);

        // Collisions: edges every other cycle while bursts run.
        for (int i = 0; i < 6; i++) strobe(16'(16'h0200 + i), 1, 1);
        repeat (20) @(negedge clk);

        // Reset dropped in the third read cycle of a burst.
        @(negedge clk);
        wrt_smpl = 1'b1;
        new_smpl = 16'h0300;
        @(negedge clk);
        wrt_smpl = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Refill from empty.
        for (int v = 16'h00A1; v <= 16'h00A5; v++) strobe(16'(v), 1, 7);
        repeat (10) @(negedge clk);

        // Randomised strobe lengths, gaps, data and occasional resets.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            strobe(16'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 8)));
        end

        repeat (40) @(negedge clk);
        chk(0, "reads_outstanding", 32'(u[0].exp_rd.size()), 0);
        chk(0, "data_outstanding",  32'(u[0].exp_vd.size()), 0);
        chk(1, "reads_outstanding", 32'(u[1].exp_rd.size()), 0);
        chk(1, "data_outstanding",  32'(u[1].exp_vd.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_queue_seq_ctrl

// File: doc/queue_seq_ctrl.md
# queue_seq_ctrl

Pointer and sequencing controller for the equalizer's circular sample queues. It accepts audio sample strobes, optionally decimates them, and writes each kept sample into an external dual-port sample RAM. Once the window holds READ_LEN samples, every new sample triggers a burst readout of the full window, oldest first, to the downstream FIR MAC. It replaces the hand-rolled pointer logic inside each low- and high-frequency queue with one parameterised block.

## Interface
- DEPTH, 1024: RAM entries; constraint DEPTH >= READ_LEN + 2; need not be a power of two.
- READ_LEN, 1021: samples per readout window (FIR taps).
- DECIM, 1: keep every DECIM-th strobe; 1 = no decimation; DECIM >= 1.
- AW, $clog2(DEPTH): address width (derived).
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- wrt_smpl  in  1  sample strobe, level signal, rising-edge detected internally.
- new_smpl  in  16  sample, sampled in the cycle the rising edge is detected.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  16  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  AW  RAM read address.
- ram_rdata  in  16  RAM read data, valid 1 cycle after ram_re (synchronous RAM).
- smpl_out  out  16  equals ram_rdata (combinational pass-through).
- smpl_vld  out  1  smpl_out carries a window sample.
- sequencing  out  1  readout burst in progress.
- full  out  1  window holds READ_LEN samples.
- overrun  out  1  sticky; a readout request was lost.

## Operation
- Edge detect: wrt_q <= wrt_smpl. Detect when wrt_smpl & ~wrt_q.
- Decimation: a mod-DECIM counter advances on each detected edge. The edge is accepted when the counter is 0, so the first edge after reset is kept.
- Accepted edge: capture new_smpl.
  - Next cycle: ram_we=1, ram_waddr=new_ptr, ram_wdata=captured value.
  - At the same edge: new_ptr <= new_ptr+1 mod DEPTH.
- Fill phase (fill_cnt < READ_LEN): fill_cnt increments on each write. The write that brings fill_cnt to READ_LEN sets full and raises a readout request.
- Full phase: each write also advances old_ptr by 1 mod DEPTH (the oldest sample is retired) and raises a readout request. fill_cnt holds at READ_LEN.
- FSM states, held in the shared package:
  - IDLE: on a request or a pending flag, go to READ; load rd_ptr=old_ptr and rd_cnt=0.
  - READ: ram_re=1, ram_raddr=rd_ptr, rd_ptr increments mod DEPTH (wraps DEPTH-1 -> 0), rd_cnt increments.
  - READ exit: when rd_cnt==READ_LEN-1, go to IDLE. If pending is set, or a request arrives in that same cycle, go directly to READ instead, reloading from the current old_ptr.
- Request during READ: the RAM write and pointer update happen immediately, and pending is set. A second request while pending is already set raises overrun; pending stays set and only one restart occurs.
- sequencing = (state==READ).
- smpl_vld = ram_re delayed 1 cycle.
- Writes never touch the window in flight, guaranteed by DEPTH >= READ_LEN+2.

## Timing
- Reset values: all outputs 0; new_ptr, old_ptr, fill_cnt, rd_ptr, rd_cnt, decimation counter, pending, wrt_q all 0; state IDLE.
- Latency from edge-detect cycle N:
  - ram_we at N+1.
  - sequencing and first ram_re at N+2.
  - first smpl_vld at N+3.
- Burst: sequencing and ram_re high exactly READ_LEN consecutive cycles; smpl_vld high READ_LEN cycles, lagging by 1.
- Back-to-back bursts (pending): no idle cycle between them.
- Reset asserted mid-burst clears everything asynchronously. sequencing and ram_re drop with rst_n, and the refill starts from empty.
- wrt_smpl held high any number of cycles counts as one edge.

## Structure
- Package eq_queue_pkg: state enum (IDLE, READ) and the 16-bit sample width constant.
- Sub-module smpl_strobe_decim: edge detector plus DECIM counter; outputs a single-cycle accept pulse and the captured sample.
- queue_seq_ctrl contains the pointers, fill counter, FSM, pending and overrun logic.

## Test plan
All scenarios use DEPTH=8, READ_LEN=5, DECIM=1 unless stated. The bench models a synchronous RAM.

- Fill: write 0x0001..0x0005 -> no sequencing for writes 1-4. After write 5, sequencing is high 5 cycles with raddr 0,1,2,3,4, and smpl_out is 1,2,3,4,5 while smpl_vld is high. full=1.
- Wrap: continue with 0x0006..0x000A.
  - Write 9 -> raddr 4,5,6,7,0, data 5,6,7,8,9.
  - Write 10 -> raddr 5,6,7,0,1, data 6..10.
- Decimation (DECIM=2): 10 edges carrying 1..10 -> only odd samples are written. First burst follows edge 9 with data 1,3,5,7,9.
- Held strobe: wrt_smpl high 20 cycles -> exactly one ram_we pulse.
- Collision: once full, assert two accepted writes during one burst -> overrun=1. Exactly one extra burst starts the cycle after the current burst's last read, reading from the latest old_ptr.
- Reset mid-burst: drop rst_n at the 3rd read cycle -> sequencing, full and overrun are 0 immediately. Five further writes of 0x00A1..0x00A5 produce raddr 0..4, data A1..A5.
